// File: rtl/shift_arbiter_2ch.sv
// Two-channel round-robin front end for one shared 32-bit rotator; result 1 cycle after acceptance, held until consumed.
// Define SHIFT_ARB_DIR_EN to add per-channel direction inputs (0=right, 1=left); default build rotates right only.
module shift_arbiter_2ch #(
  parameter logic PRIO_INIT = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid0_i,
  input  logic [31:0] req_data0_i,
  input  logic [4:0]  req_amt0_i,
  output logic        req_ready0_o,
  input  logic        req_valid1_i,
  input  logic [31:0] req_data1_i,
  input  logic [4:0]  req_amt1_i,
  output logic        req_ready1_o,
`ifdef SHIFT_ARB_DIR_EN
  input  logic        req_dir0_i,
  input  logic        req_dir1_i,
`endif
  output logic        res_valid_o,
  output logic [31:0] res_data_o,
  output logic        res_ch_o,
  input  logic        res_ready_i
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_HOLD = 1'b1;

  logic        state_q, state_d;
  logic        prio_q, prio_d;
  logic        ch_q, ch_d;
  logic [31:0] data_q, data_d;
  logic [4:0]  amt_q, amt_d;
  logic        gnt0, gnt1;
  logic [4:0]  rot_amt;
  logic [63:0] rot_wide;

`ifdef SHIFT_ARB_DIR_EN
  logic        dir_q, dir_d;
`endif

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst_i && state_q == ST_IDLE) begin
      if (req_valid0_i && (!req_valid1_i || prio_q == 1'b0)) begin
        gnt0 = 1'b1;
      end else if (req_valid1_i) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign req_ready0_o = gnt0;
  assign req_ready1_o = gnt1;

  // Operands are captured raw; the single rotator works on the held copy.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    ch_d    = ch_q;
    data_d  = data_q;
    amt_d   = amt_q;
`ifdef SHIFT_ARB_DIR_EN
    dir_d   = dir_q;
`endif
    if (state_q == ST_IDLE) begin
      if (gnt0 || gnt1) begin
        state_d = ST_HOLD;
        ch_d    = gnt1;
        data_d  = gnt1 ? req_data1_i : req_data0_i;
        amt_d   = gnt1 ? req_amt1_i : req_amt0_i;
        prio_d  = ~gnt1;
`ifdef SHIFT_ARB_DIR_EN
        dir_d   = gnt1 ? req_dir1_i : req_dir0_i;
`endif
      end
    end else if (res_ready_i) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      prio_q  <= PRIO_INIT;
      ch_q    <= 1'b0;
      data_q  <= 32'd0;
      amt_q   <= 5'd0;
`ifdef SHIFT_ARB_DIR_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      ch_q    <= ch_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
`ifdef SHIFT_ARB_DIR_EN
      dir_q   <= dir_d;
`endif
    end
  end

  // A left rotate by n is a right rotate by (32 - n) mod 32.
`ifdef SHIFT_ARB_DIR_EN
  assign rot_amt = dir_q ? (5'd0 - amt_q) : amt_q;
`else
  assign rot_amt = amt_q;
`endif

  assign rot_wide    = {data_q, data_q} >> rot_amt;
  assign res_valid_o = (state_q == ST_HOLD);
  assign res_data_o  = res_valid_o ? rot_wide[31:0] : 32'd0;
  assign res_ch_o    = res_valid_o & ch_q;

endmodule

// File: tb/tb_shift_arbiter_2ch.sv
// Bench for shift_arbiter_2ch: directed cases plus randomized traffic checked against a cycle-level reference model.
module tb_shift_arbiter_2ch;
  localparam logic PRIO = 1'b0;

  logic        clk = 1'b0;
  logic        rst, v0, v1, r0, r1, rv, rch, rr;
  logic [31:0] d0, d1, rd;
  logic [4:0]  a0, a1;
  logic        dir0, dir1;
  int          n_assert = 0;
  int          n_fail = 0;
  logic        g0, g1;

  logic        m_hold, m_prio, m_ch;
  logic [31:0] m_data;

  always #5 clk = ~clk;

  shift_arbiter_2ch #(.PRIO_INIT(PRIO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid0_i(v0), .req_data0_i(d0), .req_amt0_i(a0), .req_ready0_o(r0),
    .req_valid1_i(v1), .req_data1_i(d1), .req_amt1_i(a1), .req_ready1_o(r1),
`ifdef SHIFT_ARB_DIR_EN
    .req_dir0_i(dir0), .req_dir1_i(dir1),
`endif
    .res_valid_o(rv), .res_data_o(rd), .res_ch_o(rch), .res_ready_i(rr)
  );

  // Reference rotate written bit by bit from the definition.
  function automatic logic [31:0] rot_ref(input logic [31:0] d, input int amt, input logic left);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = left ? d[(i - amt + 32) % 32] : d[(i + amt) % 32];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs already applied; compare at the falling edge, advance model, return DUT handshakes.
  task automatic step(input string tag, output logic h0, output logic h1);
    logic e0, e1, dl0, dl1;
    #4;
    e0 = 1'b0;
    e1 = 1'b0;
    if (!rst && !m_hold) begin
      if (v0 && v1) begin
        e0 = (m_prio == 1'b0);
        e1 = (m_prio == 1'b1);
      end else begin
        e0 = v0;
        e1 = v1;
      end
    end
    chk({tag, ".rdy0"}, r0, e0);
    chk({tag, ".rdy1"}, r1, e1);
    chk({tag, ".vld"}, rv, m_hold);
    chk({tag, ".data"}, rd, m_hold ? m_data : 32'd0);
    chk({tag, ".ch"}, rch, m_hold ? m_ch : 1'b0);
    h0 = r0 & v0;
    h1 = r1 & v1;
`ifdef SHIFT_ARB_DIR_EN
    dl0 = dir0;
    dl1 = dir1;
`else
    dl0 = 1'b0;
    dl1 = 1'b0;
`endif
    if (rst) begin
      m_hold = 1'b0;
      m_prio = PRIO;
    end else if (m_hold) begin
      if (rr) m_hold = 1'b0;
    end else if (e0 || e1) begin
      m_hold = 1'b1;
      m_ch   = e1;
      m_data = e1 ? rot_ref(d1, int'(a1), dl1) : rot_ref(d0, int'(a0), dl0);
      m_prio = ~e1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int seq [8];
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0; rr = 1'b0;
    d0 = 32'd0; d1 = 32'd0; a0 = 5'd0; a1 = 5'd0; dir0 = 1'b0; dir1 = 1'b0;
    m_hold = 1'b0; m_prio = PRIO; m_ch = 1'b0; m_data = 32'd0;
    @(posedge clk);
    #1;
    v0 = 1'b1; v1 = 1'b1;
    step("reset", g0, g1);
    chk("reset.vld", rv, 1'b0);
    chk("reset.data", rd, 32'd0);
    v0 = 1'b0; v1 = 1'b0; rst = 1'b0;
    step("idle", g0, g1);

    // Single ch0 rotate by 1.
    v0 = 1'b1; d0 = 32'h8000_0001; a0 = 5'd1; rr = 1'b1;
    step("r028a", g0, g1);
    chk("r028.acc0", g0, 1'b1);
    v0 = 1'b0;
    chk("r028.vld", rv, 1'b1);
    chk("r028.data", rd, 32'hC000_0000);
    chk("r028.ch", rch, 1'b0);
    step("r028b", g0, g1);

    // Ch1 result held while consumer stalls.
    v1 = 1'b1; d1 = 32'h1234_5678; a1 = 5'd16; rr = 1'b0;
    step("r029a", g0, g1);
    v1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("r029.data", rd, 32'h5678_1234);
      chk("r029.ch", rch, 1'b1);
      v0 = 1'b1;
      step("r029h", g0, g1);
      chk("r029.noacc", {g0, g1}, 2'b00);
    end
    v0 = 1'b0; rr = 1'b1;
    step("r029c", g0, g1);
    step("r029d", g0, g1);

    // Alternating grants with both channels always requesting.
    rst = 1'b1;
    step("r030r", g0, g1);
    rst = 1'b0;
    v0 = 1'b1; v1 = 1'b1; rr = 1'b1;
    for (int k = 0; k < 8; k++) begin
      d0 = $urandom; d1 = $urandom; a0 = 5'($urandom); a1 = 5'($urandom);
      step("r030", g0, g1);
      seq[k] = g0 ? 1 : (g1 ? 2 : 0);
    end
    for (int k = 0; k < 8; k++) chk("r030.grant", seq[k], (k % 2 == 1) ? 0 : ((k % 4 == 0) ? 1 : 2));
    v0 = 1'b0; v1 = 1'b0;
    step("r030e", g0, g1);

    // Rotate extremes.
    v0 = 1'b1; d0 = 32'hDEAD_BEEF; a0 = 5'd0;
    step("r031a", g0, g1);
    v0 = 1'b0;
    chk("r031.amt0", rd, 32'hDEAD_BEEF);
    step("r031b", g0, g1);
    v1 = 1'b1; d1 = 32'h0000_0001; a1 = 5'd31;
    step("r031c", g0, g1);
    v1 = 1'b0;
    chk("r031.amt31", rd, 32'h0000_0002);
    step("r031d", g0, g1);

    // Reset in HOLD drops the result and restores priority.
    v0 = 1'b1; d0 = 32'h0000_00F0; a0 = 5'd4; rr = 1'b0;
    step("r032a", g0, g1);
    v0 = 1'b0;
    rst = 1'b1;
    step("r032r", g0, g1);
    rst = 1'b0;
    chk("r032.vld", rv, 1'b0);
    chk("r032.data", rd, 32'd0);
    v0 = 1'b1; v1 = 1'b1;
    step("r032b", g0, g1);
    chk("r032.prio", {g0, g1}, 2'b10);
    v0 = 1'b0; v1 = 1'b0; rr = 1'b1;
    step("r032c", g0, g1);

`ifdef SHIFT_ARB_DIR_EN
    v0 = 1'b1; d0 = 32'h8000_0001; a0 = 5'd1; dir0 = 1'b1;
    step("r033a", g0, g1);
    v0 = 1'b0;
    chk("r033.left", rd, 32'h0000_0003);
    step("r033b", g0, g1);
    v0 = 1'b1; dir0 = 1'b0;
    step("r033c", g0, g1);
    v0 = 1'b0;
    chk("r033.right", rd, 32'hC000_0000);
    step("r033d", g0, g1);
`endif

    // Random traffic: requesters hold until accepted, random stalls and resets.
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      rr  = ($urandom_range(0, 2) != 0);
      if (!v0 && $urandom_range(0, 1) == 1) begin
        v0 = 1'b1; d0 = $urandom; a0 = 5'($urandom); dir0 = 1'($urandom);
      end
      if (!v1 && $urandom_range(0, 1) == 1) begin
        v1 = 1'b1; d1 = $urandom; a1 = 5'($urandom); dir1 = 1'($urandom);
      end
      step("rnd", g0, g1);
      if (g0) v0 = 1'b0;
      if (g1) v1 = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
